fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 86 ++++++++
 tb/tb_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one imem read at a time, forwards the returned
// word into the instruction queue, and handles redirects from the flush controller.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  output logic        imem_rqst,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        iq_full,
  input  logic        iq_almost_full,
  output logic        iq_push,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] flush_tgt;
  logic        issue;

  assign flush_tgt = flush_pc & 32'hffff_fffc;

  // Back-to-back issue from WAIT needs room for both the word pushed now and the new one.
  always_comb begin
    issue = 1'b0;
    if (rst && !move_flush && !iq_full) begin
      unique case (state)
        StIdle:  issue = 1'b1;
        StWait:  issue = imem_resp && !iq_almost_full;
        default: issue = 1'b0;
      endcase
    end
  end

  always_comb begin
    iq_push = rst && (state == StWait) && imem_resp && !move_flush && !iq_full;
    iq_inst = iq_push ? imem_rdata : 32'h0;
    iq_pc   = iq_push ? req_pc : 32'h0;
  end

  assign imem_rmask = issue ? 4'hf : 4'h0;
  assign imem_addr  = issue ? fetch_pc : 32'h0;
  assign imem_rqst  = issue;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= StIdle;
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0;
    end else begin
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end else if (move_flush) begin
        fetch_pc <= flush_tgt;
      end
      unique case (state)
        StIdle: begin
          if (issue) state <= StWait;
        end
        StWait: begin
          if (imem_resp) state <= issue ? StWait : StIdle;
          else if (move_flush) state <= StDrop;
        end
        StDrop: begin
          if (imem_resp) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: drives inputs just after each rising edge and checks the
// combinational outputs mid-cycle against hand-computed values.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_flush;
  logic [31:0] flush_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_rqst;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        iq_full;
  logic        iq_almost_full;
  logic        iq_push;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h1eceb000)) dut (
    .clk           (clk),
    .rst           (rst),
    .move_flush    (move_flush),
    .flush_pc      (flush_pc),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rqst     (imem_rqst),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .iq_full       (iq_full),
    .iq_almost_full(iq_almost_full),
    .iq_push       (iq_push),
    .iq_inst       (iq_inst),
    .iq_pc         (iq_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Let combinational outputs settle after new inputs, well before the next edge.
  task automatic settle();
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    move_flush     = 1'b0;
    flush_pc       = 32'h0;
    imem_rdata     = 32'h0;
    imem_resp      = 1'b0;
    iq_full        = 1'b0;
    iq_almost_full = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] addr);
    check({tag, "_rmask"}, {28'h0, imem_rmask}, 32'hf);
    check({tag, "_rqst"}, {31'h0, imem_rqst}, 32'h1);
    check({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic expect_no_issue(input string tag);
    check({tag, "_rmask"}, {28'h0, imem_rmask}, 32'h0);
    check({tag, "_rqst"}, {31'h0, imem_rqst}, 32'h0);
  endtask

  task automatic expect_push(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, "_push"}, {31'h0, iq_push}, 32'h1);
    check({tag, "_inst"}, iq_inst, inst);
    check({tag, "_pc"}, iq_pc, pc);
  endtask

  task automatic expect_no_push(input string tag);
    check({tag, "_push"}, {31'h0, iq_push}, 32'h0);
    check({tag, "_inst"}, iq_inst, 32'h0);
    check({tag, "_pc"}, iq_pc, 32'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    settle();
    expect_no_issue("rst");
    check("rst_addr", imem_addr, 32'h0);
    check("rst_push", {31'h0, iq_push}, 32'h0);
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    next_cycle();

    // Streaming fetch with a response one cycle after each request.
    do_reset();
    settle();
    expect_issue("s0", 32'h1eceb000);
    next_cycle();
    imem_resp = 1'b1; imem_rdata = 32'h11110000;
    settle();
    expect_push("s1", 32'h11110000, 32'h1eceb000);
    expect_issue("s1", 32'h1eceb004);
    next_cycle();
    imem_rdata = 32'h11110004;
    settle();
    expect_push("s2", 32'h11110004, 32'h1eceb004);
    expect_issue("s2", 32'h1eceb008);
    next_cycle();
    imem_rdata = 32'h11110008;
    settle();
    expect_push("s3", 32'h11110008, 32'h1eceb008);
    next_cycle();

    // Almost-full during the response: push but no back-to-back issue.
    do_reset();
    settle();
    expect_issue("af0", 32'h1eceb000);
    next_cycle();
    imem_resp = 1'b1; imem_rdata = 32'h22220000; iq_almost_full = 1'b1;
    settle();
    expect_push("af1", 32'h22220000, 32'h1eceb000);
    expect_no_issue("af1");
    next_cycle();
    imem_resp = 1'b0; iq_full = 1'b1;
    settle();
    expect_no_issue("af2");
    next_cycle();
    iq_full = 1'b0; iq_almost_full = 1'b0;
    settle();
    expect_issue("af3", 32'h1eceb004);
    next_cycle();

    // Flush coincident with a response: word dropped, target aligned down.
    do_reset();
    settle();
    expect_issue("fr0", 32'h1eceb000);
    next_cycle();
    imem_resp = 1'b1; imem_rdata = 32'h33330000; move_flush = 1'b1; flush_pc = 32'h1eceb103;
    settle();
    expect_no_push("fr1");
    expect_no_issue("fr1");
    next_cycle();
    idle_inputs();
    settle();
    expect_issue("fr2", 32'h1eceb100);
    next_cycle();

    // Flush while waiting: the late response is discarded.
    do_reset();
    settle();
    expect_issue("fw0", 32'h1eceb000);
    next_cycle();
    move_flush = 1'b1; flush_pc = 32'h1eceb200;
    settle();
    expect_no_issue("fw1");
    next_cycle();
    idle_inputs();
    settle();
    expect_no_issue("fw2");
    next_cycle();
    settle();
    expect_no_issue("fw3");
    next_cycle();
    imem_resp = 1'b1; imem_rdata = 32'h44440000;
    settle();
    expect_no_push("fw4");
    expect_no_issue("fw4");
    next_cycle();
    idle_inputs();
    settle();
    expect_issue("fw5", 32'h1eceb200);
    next_cycle();

    // Reset mid-request followed by a stray response.
    do_reset();
    settle();
    expect_issue("rr0", 32'h1eceb000);
    next_cycle();
    do_reset();
    iq_full = 1'b1;
    settle();
    expect_no_issue("rr1");
    next_cycle();
    imem_resp = 1'b1; imem_rdata = 32'h55550000;
    settle();
    expect_no_push("rr2");
    expect_no_issue("rr2");
    next_cycle();
    idle_inputs();
    settle();
    expect_issue("rr3", 32'h1eceb000);
    next_cycle();

    // Queue full from reset: nothing issued until it drains.
    iq_full = 1'b1;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      expect_no_issue($sformatf("full%0d", i));
      next_cycle();
    end
    iq_full = 1'b0;
    settle();
    expect_issue("full5", 32'h1eceb000);
    next_cycle();

    // Response while queue is full must not push.
    imem_resp = 1'b1; imem_rdata = 32'h66660000; iq_full = 1'b1;
    settle();
    expect_no_push("fullresp");
    expect_no_issue("fullresp");
    next_cycle();
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
